// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and hazard_ctrl.
// The datapath drives hazard sources through the master modport; the controller uses the slave modport.
interface hazard_ctrl_if;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        id_uses_rt_i;
  logic [4:0]  ex_rd_i;
  logic        ex_memread_i;
  logic        branch_taken_i;
  logic        md_start_i;
  logic        pc_stall_o;
  logic        ifid_stall_o;
  logic        ifid_flush_o;
  logic        idex_bubble_o;
  logic        busy_o;
  logic [15:0] stall_cnt_o;

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_memread_i,
           branch_taken_i, md_start_i,
    output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           busy_o, stall_cnt_o
  );

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_rd_i, ex_memread_i,
           branch_taken_i, md_start_i,
    input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
           busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, taken-branch flush and fixed-latency mul/div hold for the IF/ID front end.
// Define HAZARD_CTRL_MULDIV_EN to compile in the MD_WAIT hold; without it md_start_i is ignored.
//
// state   | meaning
// IDLE    | normal issue; load-use stall or branch flush as required
// MD_WAIT | front end held while a mul/div completes (MD_LATENCY cycles)
module hazard_ctrl #(
  parameter int MD_LATENCY = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  hazard_ctrl_if.slave  bus
);

  logic        lu;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;

  assign lu = bus.ex_memread_i && (bus.ex_rd_i != 5'd0) &&
              ((bus.ex_rd_i == bus.id_rs_i) ||
               (bus.id_uses_rt_i && (bus.ex_rd_i == bus.id_rt_i)));

`ifdef HAZARD_CTRL_MULDIV_EN
  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t     state_d;
  state_t     state_q;
  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (lu) begin
          stall = 1'b1;
        end else if (bus.branch_taken_i) begin
          flush = 1'b1;
        end else if (bus.md_start_i) begin
          state_d = MD_WAIT;
          cnt_d   = MD_LATENCY[3:0];
        end
      end
      MD_WAIT: begin
        stall = 1'b1;
        busy  = 1'b1;
        // cnt_q of 0 is unreachable with a legal MD_LATENCY; treat it as the last cycle
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = bus.md_start_i & (MD_LATENCY != 0);

  always_comb begin
    stall = lu;
    flush = !lu && bus.branch_taken_i;
    busy  = 1'b0;
  end
`endif

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.pc_stall_o    = stall;
  assign bus.ifid_stall_o  = stall;
  assign bus.idex_bubble_o = stall;
  assign bus.ifid_flush_o  = flush;
  assign bus.busy_o        = busy;
  assign bus.stall_cnt_o   = stall_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the stall and flush controls of the IF/ID pipeline register, the PC write enable, and the ID/EX bubble insert. It detects load-use hazards and taken branches, and holds the front end for a fixed-latency multiply/divide operation. Stall/flush outputs are Mealy: they are combinational from the current state and ID/EX inputs, so the pipeline registers sample them at the same posedge. The block also keeps a saturating stall-cycle counter for performance monitoring.

## Interface

**Parameters**
- `MD_LATENCY`, default 4: number of front-end stall cycles following a mul/div issue. Legal range 1..15.

**Ports**
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n_i`  in  1  asynchronous active-low reset.
- `id_rs_i`  in  5  rs field of the instruction in ID.
- `id_rt_i`  in  5  rt field of the instruction in ID.
- `id_uses_rt_i`  in  1  the ID instruction reads rt.
- `ex_rd_i`  in  5  destination register of the instruction in EX.
- `ex_memread_i`  in  1  the EX instruction is a load.
- `branch_taken_i`  in  1  a branch in ID is resolved taken this cycle.
- `md_start_i`  in  1  the ID instruction is a mul/div.
- `pc_stall_o`  out  1  hold the PC.
- `ifid_stall_o`  out  1  hold the IF/ID register.
- `ifid_flush_o`  out  1  zero the IF/ID instruction.
- `idex_bubble_o`  out  1  insert a NOP into ID/EX.
- `busy_o`  out  1  the FSM is in MD_WAIT.
- `stall_cnt_o`  out  16  saturating count of cycles with `pc_stall_o` = 1.

## Operation

- States: IDLE and MD_WAIT. Internal down-counter `cnt` is 4 bits.
- Load-use hazard `lu` = `ex_memread_i` & (`ex_rd_i` != 0) & ((`ex_rd_i` == `id_rs_i`) | (`id_uses_rt_i` & (`ex_rd_i` == `id_rt_i`))).
- IDLE, evaluated in priority order:
  - `lu`: `pc_stall_o` = `ifid_stall_o` = `idex_bubble_o` = 1, `ifid_flush_o` = 0. Ignore `branch_taken_i` and `md_start_i`; the ID instruction re-presents next cycle.
  - `branch_taken_i`: `ifid_flush_o` = 1 for this cycle only, with no stall. If `md_start_i` is also set, it is ignored.
  - `md_start_i`: no stall this cycle, so the mul/div enters EX. At the next edge, go to MD_WAIT with `cnt` = `MD_LATENCY`.
  - Otherwise all control outputs are 0.
- MD_WAIT:
  - `pc_stall_o` = `ifid_stall_o` = `idex_bubble_o` = 1, and `busy_o` = 1.
  - `branch_taken_i`, `md_start_i` and `lu` are ignored.
  - Each edge decrements `cnt`. When `cnt` == 1 at an edge, go to IDLE.
  - Total MD_WAIT residency is exactly `MD_LATENCY` cycles.
- `ifid_stall_o` always equals `pc_stall_o`.
- `ifid_flush_o` and `ifid_stall_o` are never both 1.
- `stall_cnt_o` increments on every edge where `pc_stall_o` = 1. It saturates at 16'hFFFF and does not wrap.

## Timing

- Reset (asynchronous, `rst_n_i` = 0): state = IDLE, `cnt` = 0, `stall_cnt_o` = 0, `busy_o` = 0. All other outputs are then 0 unless the IDLE input rules assert them combinationally.
- Reset asserted during MD_WAIT aborts immediately. Outputs drop in the same cycle, without waiting for a clock.
- Reset deassertion is synchronised by the system; the block needs no edge to become operational.
- Output latency is 0 cycles: combinational from inputs to outputs in IDLE.
- `md_start_i` to first stall cycle: 1 cycle.
- A load-use stall lasts exactly 1 cycle, because the load then moves to MEM and `lu` clears.
- A back-to-back mul/div issues 1 cycle after leaving MD_WAIT.

## Configuration

- Macro: `HAZARD_CTRL_MULDIV_EN`.
- Defined: MD_WAIT, `cnt` and the `md_start_i` handling are compiled in, as described above.
- Undefined:
  - MD_WAIT and `cnt` are removed and `md_start_i` is ignored.
  - `busy_o` is tied to 0.
  - `MD_LATENCY` is unused.
  - Load-use, branch flush and `stall_cnt_o` behave identically to the defined case.

## Test plan

- **Load-use:** `ex_memread_i` = 1, `ex_rd_i` = 8, `id_rs_i` = 8 for 1 cycle -> stall and bubble = 1 that cycle, `stall_cnt_o` = 1. With `ex_rd_i` = 0 under the same stimulus -> no stall.
- **rt gating:** `ex_rd_i` = `id_rt_i` = 5, `id_uses_rt_i` = 0 -> no stall. With `id_uses_rt_i` = 1 -> stall.
- **Branch:** `branch_taken_i` = 1 in IDLE -> `ifid_flush_o` = 1 for 1 cycle, `pc_stall_o` = 0. `branch_taken_i` together with `lu` -> stall only, flush = 0.
- **Mul/div:** `MD_LATENCY` = 4, `md_start_i` pulse -> 0 stall in the issue cycle, then exactly 4 cycles of stall with `busy_o` = 1, then IDLE. `stall_cnt_o` = 4. `branch_taken_i` during the wait -> no flush.
- **Reset mid-wait:** assert `rst_n_i` = 0 in the 2nd MD_WAIT cycle, asynchronously (not on an edge) -> all outputs 0 immediately, `stall_cnt_o` = 0. After release -> IDLE.
- **Saturation and macro:**
  - Hold `lu` for 65 540 cycles -> `stall_cnt_o` = 16'hFFFF.
  - With the macro undefined, a `md_start_i` pulse -> no stall, `busy_o` = 0.
